// File: rtl/simd_buf_write_queue.sv
// SIMD result write queue: buffers namespace writes and drains them one namespace per handshake.
// Multi-hot requests are serialised lowest namespace first before the entry is popped.
module simd_buf_write_queue #(
  parameter int NUM_NS     = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_NS-1:0]          wr_req_in,
  input  logic [ADDR_WIDTH-1:0]      wr_addr_in,
  input  logic [DATA_WIDTH-1:0]      wr_data_in,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [NUM_NS-1:0]          out_ns_sel,
  output logic [ADDR_WIDTH-1:0]      out_addr,
  output logic [DATA_WIDTH-1:0]      out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       idle,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [NUM_NS-1:0]     req_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PW-1:0]     rptr, wptr;
  logic [OW-1:0]     occ;
  logic [NUM_NS-1:0] sent_mask;
  logic [NUM_NS-1:0] rem_mask;
  logic [NUM_NS-1:0] low_sel;
  logic              full, enq, drop, handshake, last_bit, pop;

  // Remaining namespaces of the head are its request minus those already written.
  assign rem_mask  = req_mem[rptr] & ~sent_mask;
  assign low_sel   = rem_mask & (~rem_mask + NUM_NS'(1));

  assign full      = (occ == OW'(DEPTH));
  assign enq       = (|wr_req_in) && !full;
  assign drop      = (|wr_req_in) && full;
  assign out_valid = (occ != '0);
  assign handshake = out_valid && out_ready;
  assign last_bit  = ((rem_mask & ~low_sel) == '0);
  assign pop       = handshake && last_bit;

  assign in_ready   = !full;
  assign idle       = (occ == '0);
  assign occupancy  = occ;
  assign out_ns_sel = out_valid ? low_sel : '0;
  assign out_addr   = out_valid ? addr_mem[rptr] : '0;
  assign out_data   = out_valid ? data_mem[rptr] : '0;

  // Storage needs no reset: every read is gated by out_valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      req_mem[wptr]  <= wr_req_in;
      addr_mem[wptr] <= wr_addr_in;
      data_mem[wptr] <= wr_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr      <= '0;
      wptr      <= '0;
      occ       <= '0;
      sent_mask <= '0;
      overflow  <= 1'b0;
    end else begin
      if (enq)
        wptr <= wptr + PW'(1);
      if (pop) begin
        rptr      <= rptr + PW'(1);
        sent_mask <= '0;
      end else if (handshake) begin
        sent_mask <= sent_mask | low_sel;
      end
      case ({enq, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
      // A fresh drop wins over a coincident clear.
      if (drop)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simd_buf_write_queue.sv
// Self-checking bench for simd_buf_write_queue: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_simd_buf_write_queue;

  localparam int NUM_NS = 6;
  localparam int AW     = 32;
  localparam int DW     = 64;
  localparam int DEPTH  = 8;

  typedef struct {
    logic [NUM_NS-1:0] req;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     data;
  } entry_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_NS-1:0] wr_req_in;
  logic [AW-1:0]     wr_addr_in;
  logic [DW-1:0]     wr_data_in;
  logic              in_ready;
  logic              out_valid;
  logic [NUM_NS-1:0] out_ns_sel;
  logic [AW-1:0]     out_addr;
  logic [DW-1:0]     out_data;
  logic              out_ready;
  logic [3:0]        occupancy;
  logic              idle;
  logic              overflow;
  logic              clr_overflow;

  entry_t model_q[$];
  logic   model_ovf;
  int     total_checks = 0;
  int     failed_checks = 0;

  simd_buf_write_queue #(.NUM_NS(NUM_NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_req_in(wr_req_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
    .in_ready(in_ready), .out_valid(out_valid), .out_ns_sel(out_ns_sel),
    .out_addr(out_addr), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .idle(idle), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_checks++;
    if (observed !== expected) begin
      failed_checks++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every DUT output with what the model says should be visible now.
  task automatic compareAll();
    logic [NUM_NS-1:0] exp_sel;
    logic [AW-1:0]     exp_addr;
    logic [DW-1:0]     exp_data;
    exp_sel  = '0;
    exp_addr = '0;
    exp_data = '0;
    if (model_q.size() != 0) begin
      for (int i = NUM_NS - 1; i >= 0; i--)
        if (model_q[0].req[i]) exp_sel = NUM_NS'(1) << i;
      exp_addr = model_q[0].addr;
      exp_data = model_q[0].data;
    end
    checkOutput("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
    checkOutput("out_ns_sel", 64'(out_ns_sel), 64'(exp_sel));
    checkOutput("out_addr", 64'(out_addr), 64'(exp_addr));
    checkOutput("out_data", out_data, exp_data);
    checkOutput("occupancy", 64'(occupancy), 64'(model_q.size()));
    checkOutput("in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
    checkOutput("idle", 64'(idle), 64'(model_q.size() == 0));
    checkOutput("overflow", 64'(overflow), 64'(model_ovf));
  endtask

  // One cycle: check outputs, drive inputs, advance the model, then let the clock edge happen.
  task automatic applyStimulus(input logic [NUM_NS-1:0] req, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic ordy,
                               input logic clr, input logic rst);
    bit do_hs;
    bit do_enq;
    bit do_drop;
    @(negedge clk);
    compareAll();
    wr_req_in    = req;
    wr_addr_in   = addr;
    wr_data_in   = data;
    out_ready    = ordy;
    clr_overflow = clr;
    reset        = rst;
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      do_hs   = (model_q.size() != 0) && ordy;
      do_enq  = (req != 0) && (model_q.size() < DEPTH);
      do_drop = (req != 0) && (model_q.size() == DEPTH);
      if (do_hs) begin
        model_q[0].req = model_q[0].req & (model_q[0].req - 1'b1);
        if (model_q[0].req == 0) void'(model_q.pop_front());
      end
      if (do_enq) model_q.push_back('{req, addr, data});
      if (do_drop) model_ovf = 1'b1;
      else if (clr) model_ovf = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic idleCycles(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; wr_req_in = '0; wr_addr_in = '0; wr_data_in = '0;
    out_ready = 1'b0; clr_overflow = 1'b0;
    model_ovf = 1'b0;
    repeat (2) @(posedge clk);
    applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b0);

    $display("[TB] single write");
    applyStimulus(6'b000100, 32'h0000_1234, 64'hA5, 1'b1, 1'b0, 1'b0);
    idleCycles(3, 1'b1);

    $display("[TB] multi-hot serialisation");
    applyStimulus(6'b101001, 32'hDEAD_0040, 64'h1122_3344_5566_7788, 1'b1, 1'b0, 1'b0);
    idleCycles(5, 1'b1);

    $display("[TB] backpressure and overflow");
    for (int i = 0; i < 8; i++)
      applyStimulus(NUM_NS'(1) << (i % NUM_NS), 32'(i * 16), 64'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(6'b000001, 32'hFFFF, 64'd99, 1'b0, 1'b0, 1'b0);
    idleCycles(2, 1'b0);
    idleCycles(10, 1'b1);
    applyStimulus('0, '0, '0, 1'b1, 1'b1, 1'b0);
    idleCycles(1, 1'b1);

    $display("[TB] streaming with wrap and stall");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(NUM_NS'(1) << (i % NUM_NS), 32'(100 + i), 64'(1000 + i), 1'b1, 1'b0, 1'b0);
      checkOutput("stream_occ_le1", 64'(occupancy <= 1), 64'd1);
    end
    for (int i = 0; i < 6; i++)
      applyStimulus(6'b000010, 32'(200 + i), 64'(2000 + i), (i < 1), 1'b0, 1'b0);
    idleCycles(4, 1'b0);
    idleCycles(10, 1'b1);

    $display("[TB] reset mid-drain");
    for (int i = 0; i < 3; i++)
      applyStimulus(6'b110000, 32'(300 + i), 64'(3000 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1);
    idleCycles(2, 1'b1);

    $display("[TB] overflow clear, coincident drop");
    for (int i = 0; i < 9; i++)
      applyStimulus(6'b000001, 32'(400 + i), 64'(4000 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(6'b000001, 32'h1, 64'h1, 1'b0, 1'b1, 1'b0);
    applyStimulus('0, '0, '0, 1'b0, 1'b1, 1'b0);
    idleCycles(12, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic [NUM_NS-1:0] req;
      req = ($urandom_range(0, 3) == 0) ? '0 : NUM_NS'($urandom);
      applyStimulus(req, 32'($urandom), {32'($urandom), 32'($urandom)},
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 99) == 0));
    end
    idleCycles(60, 1'b1);

    $display("[TB] %0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule
